// File: rtl/bp_me_mock_mem.sv
// Single-outstanding mock memory for a CCE: accepts one read or write command,
// waits a fixed latency, then returns a fill (read) or ack (write).
module bp_me_mock_mem #(
  parameter int paddr_width_p   = 40,
  parameter int block_width_p   = 512,
  parameter int payload_width_p = 16,
  parameter int mem_els_p       = 64,
  parameter int latency_p       = 4
) (
  input  logic                                                    clk_i,
  input  logic                                                    reset_i,
  input  logic [payload_width_p+paddr_width_p-1:0]                mem_cmd_i,
  input  logic                                                    mem_cmd_v_i,
  output logic                                                    mem_cmd_yumi_o,
  input  logic [payload_width_p+paddr_width_p+block_width_p-1:0]  mem_data_cmd_i,
  input  logic                                                    mem_data_cmd_v_i,
  output logic                                                    mem_data_cmd_yumi_o,
  output logic [payload_width_p+paddr_width_p-1:0]                mem_resp_o,
  output logic                                                    mem_resp_v_o,
  input  logic                                                    mem_resp_ready_i,
  output logic [payload_width_p+paddr_width_p+block_width_p-1:0]  mem_data_resp_o,
  output logic                                                    mem_data_resp_v_o,
  input  logic                                                    mem_data_resp_ready_i
);

  localparam int OFF_W = $clog2(block_width_p/8);
  localparam int IDX_W = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;
  localparam int CNT_W = (latency_p > 0) ? $clog2(latency_p + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  typedef struct packed {
    logic [payload_width_p-1:0] payload;
    logic [paddr_width_p-1:0]   addr;
  } cmd_s;

  typedef struct packed {
    logic [payload_width_p-1:0] payload;
    logic [paddr_width_p-1:0]   addr;
    logic [block_width_p-1:0]   data;
  } data_cmd_s;

  // Upper address bits beyond the index field are dropped, so addresses alias.
  function automatic logic [IDX_W-1:0] f_idx(input logic [paddr_width_p-1:0] a);
    return a[OFF_W +: IDX_W];
  endfunction

  state_e                     r_state;
  logic [CNT_W-1:0]           r_cnt;
  logic                       r_is_wr;
  logic [payload_width_p-1:0] r_payload;
  logic [paddr_width_p-1:0]   r_addr;
  logic [block_width_p-1:0]   r_data;
  logic [block_width_p-1:0]   r_mem [mem_els_p];

  cmd_s      w_cmd;
  data_cmd_s w_dcmd;
  cmd_s      w_new;
  logic      w_acc_wr;
  logic      w_acc_rd;
  logic      w_accept;
  logic      w_hs;

  assign w_cmd    = mem_cmd_i;
  assign w_dcmd   = mem_data_cmd_i;

  // Writes win when both valids are high; the read simply stays pending.
  assign w_acc_wr = !reset_i && (r_state == S_IDLE) && mem_data_cmd_v_i;
  assign w_acc_rd = !reset_i && (r_state == S_IDLE) && mem_cmd_v_i && !mem_data_cmd_v_i;
  assign w_accept = w_acc_wr || w_acc_rd;
  assign w_new    = w_acc_wr ? cmd_s'({w_dcmd.payload, w_dcmd.addr}) : w_cmd;

  assign w_hs = (r_state == S_RESP) && (r_is_wr ? mem_resp_ready_i : mem_data_resp_ready_i);

  assign mem_data_cmd_yumi_o = w_acc_wr;
  assign mem_cmd_yumi_o      = w_acc_rd;

  assign mem_resp_v_o      = !reset_i && (r_state == S_RESP) &&  r_is_wr;
  assign mem_data_resp_v_o = !reset_i && (r_state == S_RESP) && !r_is_wr;
  assign mem_resp_o        = {r_payload, r_addr};
  assign mem_data_resp_o   = {r_payload, r_addr, r_data};

  always_ff @(posedge clk_i) begin
    if (w_acc_wr) r_mem[f_idx(w_dcmd.addr)] <= w_dcmd.data;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_is_wr <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_payload <= w_new.payload;
            r_addr    <= w_new.addr;
            r_is_wr   <= w_acc_wr;
            if (latency_p == 0) begin
              r_state <= S_RESP;
              if (w_acc_rd) r_data <= r_mem[f_idx(w_new.addr)];
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= CNT_W'(latency_p);
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_RESP;
            r_cnt   <= '0;
            // Fill data is sampled on RESP entry and held until handshake.
            if (!r_is_wr) r_data <= r_mem[f_idx(r_addr)];
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          if (w_hs) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
